// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate truth-table sequencer.
//   state_t      : sequencer FSM states
//   TT_*         : expected-Y vectors for common 2-input gates (bit i = Y for stim==i)
//   num_vectors  : number of input combinations for a given input count
package gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] TT_AND2 = 4'b1000;
    localparam logic [3:0] TT_OR2  = 4'b1110;
    localparam logic [3:0] TT_XOR2 = 4'b0110;

    function automatic int unsigned num_vectors(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/gate_seq_hold_timer.sv
// Hold-window counter: counts cycles within one vector window and wraps.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to 0 (takes priority over en)
//   en       : advance count; wraps to 0 after HOLD_CYCLES-1
//   last     : count is on the final cycle of the window
module gate_seq_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [CW-1:0] count;

    assign last = (count == CW'(HOLD_CYCLES - 1));

    // Counter with wrap at window end
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer: walks stim through every input combination, holds
// each for HOLD_CYCLES, samples y_in on the last cycle of each window and
// compares it against EXPECT[stim].
//   clk, rst        : clock, synchronous active-high reset
//   start, abort    : begin a run from IDLE / end a run early (no done)
//   stim            : gate input vector (also the current vector index)
//   y_in            : gate output under test
//   busy, done      : run in progress / one-cycle completion pulse
//   pass            : last completed run had no mismatches
//   err_count       : mismatches in the current or last run
//   first_fail_idx  : index of the first mismatch, valid when fail_valid
module gate_tt_sequencer
    import gate_seq_pkg::*;
#(
    parameter int unsigned                      N_IN        = 2,
    parameter int unsigned                      HOLD_CYCLES = 7,
    parameter logic [num_vectors(N_IN)-1:0]     EXPECT      = TT_AND2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] stim,
    input  logic            y_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_idx,
    output logic            fail_valid
);

    localparam int unsigned NV = num_vectors(N_IN);
    localparam int unsigned EW = N_IN + 1;

    state_t          state_q, state_n;
    logic [N_IN-1:0] stim_n;
    logic            busy_n, done_n, pass_n, fv_n;
    logic [N_IN:0]   err_n;
    logic [N_IN-1:0] ffi_n;
    logic            hc_clr, hc_en, hc_last;

    gate_seq_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold (
        .clk  (clk),
        .rst  (rst),
        .clr  (hc_clr),
        .en   (hc_en),
        .last (hc_last)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            stim           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '0;
            fail_valid     <= 1'b0;
        end else begin
            state_q        <= state_n;
            stim           <= stim_n;
            busy           <= busy_n;
            done           <= done_n;
            pass           <= pass_n;
            err_count      <= err_n;
            first_fail_idx <= ffi_n;
            fail_valid     <= fv_n;
        end
    end

    // Next state and next output values; stim doubles as the vector index
    always_comb begin
        state_n = state_q;
        stim_n  = stim;
        busy_n  = busy;
        done_n  = 1'b0;
        pass_n  = pass;
        err_n   = err_count;
        ffi_n   = first_fail_idx;
        fv_n    = fail_valid;
        hc_clr  = 1'b0;
        hc_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    stim_n  = '0;
                    busy_n  = 1'b1;
                    pass_n  = 1'b0;
                    err_n   = '0;
                    ffi_n   = '0;
                    fv_n    = 1'b0;
                    hc_clr  = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                    stim_n  = '0;
                    busy_n  = 1'b0;
                    hc_clr  = 1'b1;
                end else begin
                    hc_en = 1'b1;
                    if (hc_last) begin
                        if (y_in != EXPECT[stim]) begin
                            err_n = err_count + EW'(1);
                            if (!fail_valid) begin
                                ffi_n = stim;
                                fv_n  = 1'b1;
                            end
                        end
                        if (stim == N_IN'(NV - 1)) begin
                            // pass uses err_n so the final sample is included
                            state_n = DONE;
                            stim_n  = '0;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            pass_n  = (err_n == '0);
                            hc_clr  = 1'b1;
                        end else begin
                            stim_n = stim + N_IN'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Directed bench for gate_tt_sequencer: a HOLD_CYCLES=7 instance driven by a
// selectable gate model and a HOLD_CYCLES=1 instance driven by an AND2 model.
module tb_gate_tt_sequencer;
    import gate_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // HOLD_CYCLES = 7 instance
    logic       start = 1'b0, abort = 1'b0;
    logic [1:0] stim;
    logic       y_in;
    logic       busy, done, pass, fail_valid;
    logic [2:0] err_count;
    logic [1:0] first_fail_idx;
    int         mode = 0;

    // HOLD_CYCLES = 1 instance
    logic       start1 = 1'b0, abort1 = 1'b0;
    logic [1:0] stim1;
    logic       y1;
    logic       busy1, done1, pass1, fail_valid1;
    logic [2:0] err_count1;
    logic [1:0] first_fail_idx1;
    int         mode1 = 0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Gate under test: 0=AND2 1=OR2 2=tied 0 3=tied 1
    function automatic logic gate(input int m, input logic [1:0] s);
        case (m)
            0:       return s[0] & s[1];
            1:       return s[0] | s[1];
            2:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign y_in = gate(mode, stim);
    assign y1   = gate(mode1, stim1);

    gate_tt_sequencer #(.N_IN(2), .HOLD_CYCLES(7), .EXPECT(TT_AND2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .stim(stim),
        .y_in(y_in), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_idx(first_fail_idx),
        .fail_valid(fail_valid)
    );

    gate_tt_sequencer #(.N_IN(2), .HOLD_CYCLES(1), .EXPECT(TT_AND2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .stim(stim1),
        .y_in(y1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err_count1), .first_fail_idx(first_fail_idx1),
        .fail_valid(fail_valid1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full HOLD_CYCLES=7 run started at cycle 0; done expected at cycle 29
    task automatic full_run(input int m, input int ee, input logic efv,
                            input int effi, input logic ep);
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 28; c++) begin
            chk("run_stim", 32'(stim), 32'((c - 1) / 7));
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
            tick();
        end
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_stim", 32'(stim), 32'd0);
        chk("end_pass", 32'(pass), 32'(ep));
        chk("end_err",  32'(err_count), 32'(ee));
        chk("end_fv",   32'(fail_valid), 32'(efv));
        chk("end_ffi",  32'(first_fail_idx), 32'(effi));
        // start during DONE must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_done",  32'(done), 32'd0);
        chk("post_busy",  32'(busy), 32'd0);
        chk("hold_pass",  32'(pass), 32'(ep));
        chk("hold_err",   32'(err_count), 32'(ee));
        chk("hold_ffi",   32'(first_fail_idx), 32'(effi));
        tick();
        chk("idle_busy",  32'(busy), 32'd0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_stim", 32'(stim), 32'd0);
        chk("rst_err",  32'(err_count), 32'd0);
        chk("rst_ffi",  32'(first_fail_idx), 32'd0);
        chk("rst_fv",   32'(fail_valid), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        rst = 1'b0;
        tick();

        // AND2 matches; OR2 fails at 1,2; tied-0 fails at 3; tied-1 fails at 0,1,2
        full_run(0, 0, 1'b0, 0, 1'b1);
        full_run(1, 2, 1'b1, 1, 1'b0);
        full_run(2, 1, 1'b1, 3, 1'b0);
        full_run(3, 3, 1'b1, 0, 1'b0);

        // Reset mid-run at cycle 10 (tied-1 so err_count is already 1)
        mode  = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("pre_rst_err",  32'(err_count), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_stim", 32'(stim), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_stim", 32'(stim), 32'd0);
        chk("mid_rst_err",  32'(err_count), 32'd0);
        chk("mid_rst_pass", 32'(pass), 32'd0);
        chk("mid_rst_fv",   32'(fail_valid), 32'd0);
        for (int i = 0; i < 25; i++) begin
            chk("mid_rst_nodone", 32'(done), 32'd0);
            tick();
        end
        full_run(0, 0, 1'b0, 0, 1'b1);

        // Re-start while busy at cycle 5, abort at cycle 12
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_stim6", 32'(stim), 32'd0);
        tick();
        tick();
        chk("restart_stim8", 32'(stim), 32'd1);
        chk("restart_busy8", 32'(busy), 32'd1);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_stim", 32'(stim), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
        chk("abort_err",  32'(err_count), 32'd0);
        for (int i = 0; i < 20; i++) begin
            chk("abort_nodone", 32'(done), 32'd0);
            tick();
        end

        // start and abort together in IDLE: start wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_wins_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort2_busy", 32'(busy), 32'd0);
        tick();

        // HOLD_CYCLES=1, AND2: stim 0..3 on cycles 1..4, done at 5
        mode1  = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("h1_stim", 32'(stim1), 32'(c - 1));
            chk("h1_busy", 32'(busy1), 32'd1);
            chk("h1_done", 32'(done1), 32'd0);
            tick();
        end
        chk("h1_end_done", 32'(done1), 32'd1);
        chk("h1_end_pass", 32'(pass1), 32'd1);
        chk("h1_end_err",  32'(err_count1), 32'd0);
        chk("h1_end_fv",   32'(fail_valid1), 32'd0);
        tick();
        chk("h1_post_done", 32'(done1), 32'd0);

        // HOLD_CYCLES=1 with tied-0 gate: only index 3 mismatches
        mode1  = 2;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (4) tick();
        chk("h1z_done", 32'(done1), 32'd1);
        chk("h1z_pass", 32'(pass1), 32'd0);
        chk("h1z_err",  32'(err_count1), 32'd1);
        chk("h1z_ffi",  32'(first_fail_idx1), 32'd3);
        chk("h1z_fv",   32'(fail_valid1), 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
